mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 4, the number of consecutive fetch denials that forces a fetch grant.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have ports i_req  input  1 and i_addr  input  ADDR_W, forming the instruction-fetch request.
REQ-007 The block SHALL have ports i_rdata  output  DATA_W and i_valid  output  1, forming the fetch response.
REQ-008 The block SHALL have ports d_req  input  1, d_we  input  1, d_addr  input  ADDR_W and d_wdata  input  DATA_W, forming the data-stage request.
REQ-009 The block SHALL have ports d_rdata  output  DATA_W and d_valid  output  1, forming the data response.
REQ-010 The block SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  ADDR_W and mem_wdata  output  DATA_W, forming the shared single-port memory command.
REQ-011 The block SHALL have ports mem_rdata  input  DATA_W and mem_ready  input  1, forming the memory completion (latency 1..N cycles).
REQ-012 The block SHALL have ports stallF  output  1 and stallM  output  1, the stall requests to the hazard unit.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY_I and BUSY_D.
REQ-014 In IDLE with d_req=1, the FSM SHALL latch d_addr/d_wdata/d_we and move to BUSY_D, unless the starvation override (REQ-016) applies.
REQ-015 In IDLE with d_req=0 and i_req=1, the FSM SHALL latch i_addr (we=0) and move to BUSY_I.
REQ-016 In IDLE with i_req=1 and starve_cnt==STARVE_MAX, the FSM SHALL grant fetch (BUSY_I) even if d_req=1.
REQ-017 mem_req SHALL be 1 exactly while the FSM is in BUSY_I or BUSY_D; mem_addr/mem_we/mem_wdata SHALL come from the latched registers and stay stable throughout BUSY.
REQ-018 In a BUSY state with mem_ready=1, the FSM SHALL return to IDLE, so at least one IDLE cycle separates grants.
REQ-019 On a BUSY_I completion, i_valid SHALL be 1 for exactly the next cycle and i_rdata SHALL be registered from mem_rdata.
REQ-020 On a BUSY_D completion, d_valid SHALL pulse for one cycle; d_rdata SHALL update only for reads and hold its value on writes.
REQ-021 Minimum request-to-valid latency SHALL be 3 cycles: grant in cycle N, mem_ready in N+1, valid in N+2.
REQ-022 stallF SHALL equal i_req & ~i_valid and stallM SHALL equal d_req & ~d_valid, both combinational.
REQ-023 Requesters SHALL hold req and fields until valid; if a requester drops req mid-BUSY, the transaction SHALL still complete and the valid SHALL still pulse.
REQ-024 mem_ready sampled in IDLE SHALL be ignored.
REQ-025 starve_cnt SHALL increment, saturating at STARVE_MAX, on each grant to data while i_req=1, and SHALL clear on every fetch grant.

Reset
REQ-026 While rst=0, the FSM SHALL be in IDLE and mem_req, i_valid, d_valid, i_rdata, d_rdata, starve_cnt and all latched command registers SHALL be 0.
REQ-027 Reset asserted mid-BUSY SHALL drop mem_req immediately (asynchronously), abandon the transaction and produce no valid pulse after release.

Configuration
REQ-028 With macro MEM_PORT_ARBITER_STARVE_GUARD_EN defined, starve_cnt and the REQ-016 override SHALL be present.
REQ-029 With MEM_PORT_ARBITER_STARVE_GUARD_EN undefined, data SHALL have strict priority, no counter logic SHALL exist, and STARVE_MAX SHALL be unused.

Verification
REQ-030 Bench: i_req=1, i_addr=0x10, mem_ready one cycle after grant, mem_rdata=0x00500093 -> mem_req high 1 cycle, i_valid pulses in cycle 3 with i_rdata=0x00500093.
REQ-031 Bench: i_req and d_req both asserted, d_we=0, d_addr=0x100 -> d granted first with mem_addr=0x100, then fetch granted; stallF stays 1 until i_valid.
REQ-032 Bench: guard enabled, STARVE_MAX=4, d_req held high with back-to-back loads, i_req high -> fifth grant goes to fetch; guard disabled -> fetch is never granted while d_req=1.
REQ-033 Bench: d_we=1, d_wdata=0xDEADBEEF, with mem_ready delayed 3 cycles -> mem_we=1 and mem_wdata stable for 4 cycles, d_valid pulses, d_rdata unchanged.
REQ-034 Bench: rst driven low during BUSY_D -> mem_req=0 in the same cycle, and no d_valid pulse after release.
REQ-035 Bench: mem_ready=1 pulsed while in IDLE with no requests -> no state change and no valid pulse.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Define MEM_PORT_ARBITER_STARVE_GUARD_EN to bound how long data can starve fetch.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stallF,
    output logic              stallM
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              grant_i;
    logic              grant_d;
    logic              starved;
    logic              done_i;
    logic              done_d;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              cmd_we;

`ifdef MEM_PORT_ARBITER_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // Counts data grants that bypassed a waiting fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && i_req && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign starved = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_req && (starved || !d_req)) begin
                    grant_i  = 1'b1;
                    state_nx = BUSY_I;
                end else if (d_req) begin
                    grant_d  = 1'b1;
                    state_nx = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign done_i = (state == BUSY_I) && mem_ready;
    assign done_d = (state == BUSY_D) && mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_we    <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant_i) begin
                cmd_addr  <= i_addr;
                cmd_wdata <= '0;
                cmd_we    <= 1'b0;
            end else if (grant_d) begin
                cmd_addr  <= d_addr;
                cmd_wdata <= d_wdata;
                cmd_we    <= d_we;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_valid <= done_i;
            d_valid <= done_d;
            if (done_i) begin
                i_rdata <= mem_rdata;
            end
            // Writes leave the last load result visible.
            if (done_d && !cmd_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = (state != IDLE);
    assign mem_we    = cmd_we;
    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

    assign stallF = i_req & ~i_valid;
    assign stallM = d_req & ~d_valid;

endmodule
